// File: rtl/frame_reg_port.sv
// Frame-counter register port: $4017 mode/IRQ-inhibit write with its delayed apply,
// plus the frame IRQ flag and its $4015 status read.
module frame_reg_port (
  input  logic       CLK,
  input  logic       n_RES,
  input  logic       CPU_CE,
  input  logic       ACLK_CE,
  input  logic       REG_SEL,
  input  logic [4:0] A,
  input  logic       RnW,
  input  logic [7:0] D_IN,
  input  logic       FRAME_IRQ_SET,
  output logic [7:0] D_OUT,
  output logic       D_OE,
  output logic       MODE,
  output logic       IRQ_INHIBIT,
  output logic       SEQ_RESET,
  output logic       QH_NOW,
  output logic       FRAME_IRQ,
  output logic       n_IRQ
);

  logic       wr_4017;
  logic       rd_4015;
  logic       apply;
  logic       inhibit_eff;
  logic [2:0] delay_cnt;
  logic       pend_mode;
  logic       pend_inhibit;

  assign wr_4017 = CPU_CE && REG_SEL && (A == 5'h17) && !RnW;
  assign rd_4015 = REG_SEL && (A == 5'h15) && RnW;

  // A non-zero counter means a write is pending; a fresh write overrides an apply due this cycle.
  assign apply       = CPU_CE && !wr_4017 && (delay_cnt == 3'd1);
  assign inhibit_eff = apply ? pend_inhibit : IRQ_INHIBIT;

  assign D_OE  = rd_4015;
  assign D_OUT = rd_4015 ? {1'b0, FRAME_IRQ, 6'b0} : 8'h00;
  assign n_IRQ = ~FRAME_IRQ;

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      delay_cnt    <= 3'd0;
      pend_mode    <= 1'b0;
      pend_inhibit <= 1'b0;
      MODE         <= 1'b0;
      IRQ_INHIBIT  <= 1'b0;
      SEQ_RESET    <= 1'b0;
      QH_NOW       <= 1'b0;
      FRAME_IRQ    <= 1'b0;
    end else begin
      SEQ_RESET <= 1'b0;
      QH_NOW    <= 1'b0;
      if (CPU_CE) begin
        if (wr_4017) begin
          pend_mode    <= D_IN[7];
          pend_inhibit <= D_IN[6];
          delay_cnt    <= ACLK_CE ? 3'd3 : 3'd4;
        end else if (delay_cnt != 3'd0) begin
          delay_cnt <= delay_cnt - 3'd1;
        end

        if (apply) begin
          MODE        <= pend_mode;
          IRQ_INHIBIT <= pend_inhibit;
          SEQ_RESET   <= 1'b1;
          QH_NOW      <= pend_mode;
        end

        // Inhibit-write clear beats a set, which in turn beats the status-read clear.
        if (wr_4017 && D_IN[6])
          FRAME_IRQ <= 1'b0;
        else if (FRAME_IRQ_SET && !inhibit_eff)
          FRAME_IRQ <= 1'b1;
        else if (rd_4015)
          FRAME_IRQ <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_reg_port.sv
// Scoreboard bench for frame_reg_port: stimulus pushes expected applies/reads,
// a negedge monitor pops and compares whenever the DUT pulses SEQ_RESET or drives D_OE.
module tb_frame_reg_port;

  logic       CLK = 1'b0;
  logic       n_RES;
  logic       CPU_CE, ACLK_CE, REG_SEL, RnW, FRAME_IRQ_SET;
  logic [4:0] A;
  logic [7:0] D_IN;
  logic [7:0] D_OUT;
  logic       D_OE, MODE, IRQ_INHIBIT, SEQ_RESET, QH_NOW, FRAME_IRQ, n_IRQ;

  frame_reg_port dut (
    .CLK(CLK), .n_RES(n_RES), .CPU_CE(CPU_CE), .ACLK_CE(ACLK_CE),
    .REG_SEL(REG_SEL), .A(A), .RnW(RnW), .D_IN(D_IN),
    .FRAME_IRQ_SET(FRAME_IRQ_SET), .D_OUT(D_OUT), .D_OE(D_OE),
    .MODE(MODE), .IRQ_INHIBIT(IRQ_INHIBIT), .SEQ_RESET(SEQ_RESET),
    .QH_NOW(QH_NOW), .FRAME_IRQ(FRAME_IRQ), .n_IRQ(n_IRQ)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    int   ce;
    logic mode;
    logic inh;
  } apply_t;

  apply_t     sb_apply[$];
  logic [7:0] sb_read[$];
  int         n_checks = 0;
  int         n_fails  = 0;
  int         ce_cnt   = 0;
  bit         even     = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: decoupled from stimulus, samples on the falling edge.
  always @(negedge CLK) begin
    if (n_RES === 1'b1) begin
      if (SEQ_RESET === 1'b1) begin
        if (sb_apply.size() == 0) begin
          check("unexpected_seq_reset", 1, 0);
        end else begin
          apply_t e;
          e = sb_apply.pop_front();
          check("apply_ce_index", ce_cnt, e.ce);
          check("apply_mode_inh_qh", {MODE, IRQ_INHIBIT, QH_NOW}, {e.mode, e.inh, e.mode});
        end
      end else if (QH_NOW === 1'b1) begin
        check("qh_without_seq_reset", 1, 0);
      end
      if (D_OE === 1'b1) begin
        if (sb_read.size() == 0) begin
          check("unexpected_d_oe", 1, 0);
        end else begin
          logic [7:0] r;
          r = sb_read.pop_front();
          check("read_data", D_OUT, r);
        end
      end
    end
  end

  // One CPU cycle (optionally without CPU_CE), followed by one idle CLK with no CPU_CE.
  task automatic cycle(input bit ce, input bit sel, input logic [4:0] a, input bit rnw,
                       input logic [7:0] d, input bit irqset);
    CPU_CE = ce; ACLK_CE = ce & even; REG_SEL = sel; A = a; RnW = rnw; D_IN = d;
    FRAME_IRQ_SET = irqset;
    @(posedge CLK); #1;
    if (ce) begin
      ce_cnt++;
      even = !even;
    end
    CPU_CE = 0; ACLK_CE = 0; REG_SEL = 0; A = 0; RnW = 1; D_IN = 0; FRAME_IRQ_SET = 0;
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 5'h00, 1, 8'h00, 0);
  endtask

  task automatic align(input bit want_even);
    if (even != want_even) idle(1);
  endtask

  task automatic push_apply(input logic [7:0] d);
    apply_t e;
    e.ce   = ce_cnt + 1 + (even ? 3 : 4);
    e.mode = d[7];
    e.inh  = d[6];
    sb_apply.push_back(e);
  endtask

  task automatic wr17(input logic [7:0] d, input bit expect_apply);
    if (expect_apply) push_apply(d);
    cycle(1, 1, 5'h17, 0, d, 0);
  endtask

  task automatic rd15(input logic [7:0] exp, input bit irqset);
    sb_read.push_back(exp);
    cycle(1, 1, 5'h15, 1, 8'h00, irqset);
  endtask

  initial begin
    n_RES = 0; CPU_CE = 0; ACLK_CE = 0; REG_SEL = 0; A = 0; RnW = 1; D_IN = 0;
    FRAME_IRQ_SET = 0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", {MODE, IRQ_INHIBIT, FRAME_IRQ, n_IRQ, SEQ_RESET, QH_NOW, D_OE, D_OUT},
          {7'b0001000, 8'h00});
    n_RES = 1;
    idle(6);

    // Even-cycle write: 3-CE delay, MODE=1 with QH_NOW.
    align(1);
    wr17(8'h80, 1);
    idle(6);
    check("mode_after_80", MODE, 1'b1);

    // Odd-cycle write: 4-CE delay, MODE=0, no QH_NOW.
    align(0);
    wr17(8'h00, 1);
    idle(6);
    check("mode_after_00", MODE, 1'b0);

    // IRQ set, status read returns it and clears it.
    cycle(1, 0, 5'h00, 1, 8'h00, 1);
    check("n_irq_after_set", n_IRQ, 1'b0);
    rd15(8'h40, 0);
    rd15(8'h00, 0);
    check("n_irq_after_read", n_IRQ, 1'b1);

    // Inhibit write clears the flag at the strobe and blocks later sets once applied.
    cycle(1, 0, 5'h00, 1, 8'h00, 1);
    check("irq_set_again", FRAME_IRQ, 1'b1);
    align(1);
    wr17(8'h40, 1);
    check("irq_clear_at_strobe", FRAME_IRQ, 1'b0);
    idle(5);
    check("inhibit_applied", IRQ_INHIBIT, 1'b1);
    cycle(1, 0, 5'h00, 1, 8'h00, 1);
    check("set_blocked_by_inhibit", {FRAME_IRQ, n_IRQ}, 2'b01);
    wr17(8'h00, 1);
    idle(6);

    // Read coincident with set: read sees 0, set wins.
    rd15(8'h00, 1);
    check("set_beats_read_clear", FRAME_IRQ, 1'b1);
    rd15(8'h40, 0);
    check("cleared_by_read", FRAME_IRQ, 1'b0);

    // Set coincident with an inhibit write: clear wins.
    push_apply(8'h40);
    cycle(1, 1, 5'h17, 0, 8'h40, 1);
    check("write_clear_beats_set", FRAME_IRQ, 1'b0);
    idle(6);
    wr17(8'h00, 1);
    idle(6);
    check("inhibit_released", IRQ_INHIBIT, 1'b0);

    // Back-to-back writes: second replaces the first, one apply only.
    wr17(8'h80, 0);
    wr17(8'h00, 1);
    idle(7);
    check("replaced_pending_mode", MODE, 1'b0);

    // Other offsets and strobes without CPU_CE change nothing.
    cycle(1, 1, 5'h16, 0, 8'hC0, 0);
    cycle(0, 1, 5'h17, 0, 8'hC0, 0);
    cycle(0, 0, 5'h00, 1, 8'h00, 1);
    idle(6);
    check("no_effect_mode_inh_irq", {MODE, IRQ_INHIBIT, FRAME_IRQ}, 3'b000);
    REG_SEL = 1; A = 5'h14; RnW = 1;
    #1;
    check("other_read_no_drive", {D_OE, D_OUT}, 9'h000);
    REG_SEL = 0; A = 0;
    @(posedge CLK); #1;

    // Reset mid-delay discards the pending write.
    wr17(8'h80, 0);
    idle(2);
    n_RES = 0;
    #1;
    check("reset_mid_delay", {MODE, IRQ_INHIBIT, FRAME_IRQ, n_IRQ, SEQ_RESET, QH_NOW},
          6'b000100);
    repeat (3) @(posedge CLK);
    #1;
    n_RES = 1;
    even = 1'b1;
    idle(8);
    check("mode_after_reset_release", MODE, 1'b0);

    check("apply_queue_drained", sb_apply.size(), 0);
    check("read_queue_drained", sb_read.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
